// File: rtl/main_memory.sv
// main_memory: backing data memory below the data cache.
//   Word-addressed array (2**ADDR_W x 32) with a fixed multi-cycle latency.
//   A read returns the whole 4-word block containing WA; a write stores one
//   word. Each transaction ends with a one-cycle `ready` strobe.
//
// Ports:
//   clk       clock, all state on rising edge
//   RST       synchronous active-high reset (memory contents untouched)
//   MemRead   block read request, held until ready
//   MemWrite  word write request, held until ready (wins over MemRead)
//   WA        word address; block base = WA[ADDR_W-1:2]
//   WD        write data
//   RD        registered block {word3, word2, word1, word0}
//   ready     one-cycle completion strobe
//   busy      high while a transaction is in flight
//
// Optional: define MAIN_MEM_STATS_EN to add saturating rd_count / wr_count
// outputs counting completed reads and writes.

module main_memory #(
    parameter int ADDR_W    = 10,
    parameter int READ_LAT  = 4,
    parameter int WRITE_LAT = 4
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] WA,
    input  logic [31:0]       WD,
    output logic [127:0]      RD,
    output logic              ready,
    output logic              busy
`ifdef MAIN_MEM_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic [ADDR_W-1:0] wa_q, wa_nx;
    logic [31:0]       wd_q, wd_nx;
    logic              rd_fire, wr_fire;

    logic [31:0] mem [0:DEPTH-1] = '{default: 32'd0};

    // Latched block index for reads (low two address bits cleared at accept).
    logic [ADDR_W-3:0] blk;
    assign blk  = wa_q[ADDR_W-1:2];
    assign busy = (state != IDLE);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        wa_nx    = wa_q;
        wd_nx    = wd_q;
        rd_fire  = 1'b0;
        wr_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (MemWrite) begin
                    wa_nx    = WA;
                    wd_nx    = WD;
                    cnt_nx   = 4'(WRITE_LAT - 1);
                    state_nx = WR_WAIT;
                end else if (MemRead) begin
                    wa_nx    = {WA[ADDR_W-1:2], 2'b00};
                    cnt_nx   = 4'(READ_LAT - 1);
                    state_nx = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt == 4'd0) begin
                    rd_fire  = 1'b1;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            WR_WAIT: begin
                if (cnt == 4'd0) begin
                    wr_fire  = 1'b1;
                    state_nx = DONE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= 4'd0;
            wa_q  <= '0;
            wd_q  <= 32'd0;
            ready <= 1'b0;
            RD    <= 128'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            wa_q  <= wa_nx;
            wd_q  <= wd_nx;
            // ready is only ever set on the fire edge, so DONE clears it.
            ready <= rd_fire | wr_fire;
            if (rd_fire)
                RD <= {mem[{blk, 2'd3}], mem[{blk, 2'd2}],
                       mem[{blk, 2'd1}], mem[{blk, 2'd0}]};
        end
    end

    // Array has no reset; a reset on the commit edge aborts the write.
    always_ff @(posedge clk) begin
        if (wr_fire && !RST)
            mem[wa_q] <= wd_q;
    end

`ifdef MAIN_MEM_STATS_EN
    always_ff @(posedge clk) begin
        if (RST) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else begin
            if (rd_fire && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            if (wr_fire && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        end
    end
`endif

endmodule
